// File: rtl/sparc_exu_rrreq_que.sv
// Per-thread request queues feeding the EXU 4-way round-robin arbiter.
// Holds DEPTH entries per thread, pops the single granted head on advance.
module sparc_exu_rrreq_que #(
  parameter int DW    = 8,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          se,
  input  logic          enq_vld,
  input  logic [1:0]    enq_tid,
  input  logic [DW-1:0] enq_data,
  output logic [3:0]    enq_rdy,
  output logic [3:0]    req_vec,
  input  logic [3:0]    grant_vec,
  input  logic          advance,
  output logic          deq_vld,
  output logic [1:0]    deq_tid,
  output logic [DW-1:0] deq_data,
  output logic          err_ovf,
  output logic          err_gnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [3:0][DW-1:0] head_data;
  logic [3:0]         eg;
  logic               eg_one_hot;
  logic               eg_multi;
  logic               pop;
  logic               bad_advance;
  logic               unused_se;

  assign unused_se = se;

  // Masking by req_vec removes the arbiter's idle park on thread 0.
  assign eg         = grant_vec & req_vec;
  assign eg_one_hot = (eg != 4'b0000) && ((eg & (eg - 4'd1)) == 4'b0000);
  assign eg_multi   = (eg != 4'b0000) && !eg_one_hot;
  assign deq_vld    = eg_one_hot;
  assign pop        = advance && deq_vld;

  always_comb begin
    deq_tid = 2'd0;
    for (int t = 0; t < 4; t++) begin
      if (eg_one_hot && eg[t]) deq_tid = 2'(t);
    end
  end

  assign deq_data = deq_vld ? head_data[deq_tid] : '0;

  // Advancing with a grant on an idle thread other than 0 is a protocol error.
  assign bad_advance = advance && !deq_vld && ((grant_vec & ~req_vec & 4'b1110) != 4'b0000);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_thr
      logic [CW-1:0] count_reg;
      logic [PW-1:0] rd_ptr_reg;
      logic [PW-1:0] wr_ptr_reg;
      logic [DW-1:0] mem [DEPTH];
      logic          enq_hit;
      logic          pop_hit;

      assign enq_rdy[gi]   = (count_reg < CW'(DEPTH));
      assign req_vec[gi]   = (count_reg != '0);
      assign enq_hit       = enq_vld && (enq_tid == 2'(gi)) && enq_rdy[gi];
      assign pop_hit       = pop && (deq_tid == 2'(gi));
      assign head_data[gi] = mem[rd_ptr_reg];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          count_reg  <= '0;
          rd_ptr_reg <= '0;
          wr_ptr_reg <= '0;
        end else begin
          if (enq_hit) wr_ptr_reg <= wr_ptr_reg + PW'(1);
          if (pop_hit) rd_ptr_reg <= rd_ptr_reg + PW'(1);
          case ({enq_hit, pop_hit})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
          endcase
        end
      end

      // Payload storage is deliberately left out of reset.
      always_ff @(posedge clk) begin
        if (enq_hit) mem[wr_ptr_reg] <= enq_data;
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_ovf <= 1'b0;
      err_gnt <= 1'b0;
    end else begin
      if (enq_vld && !enq_rdy[enq_tid]) err_ovf <= 1'b1;
      if (eg_multi || bad_advance)      err_gnt <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sparc_exu_rrreq_que.sv
// Randomised and directed bench for sparc_exu_rrreq_que against a queue-based model.
module tb_sparc_exu_rrreq_que;
  localparam int DW    = 8;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          se = 1'b0;
  logic          enq_vld = 1'b0;
  logic [1:0]    enq_tid = 2'd0;
  logic [DW-1:0] enq_data = '0;
  logic [3:0]    enq_rdy;
  logic [3:0]    req_vec;
  logic [3:0]    grant_vec = 4'b0;
  logic          advance = 1'b0;
  logic          deq_vld;
  logic [1:0]    deq_tid;
  logic [DW-1:0] deq_data;
  logic          err_ovf;
  logic          err_gnt;

  sparc_exu_rrreq_que #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .se(se),
    .enq_vld(enq_vld), .enq_tid(enq_tid), .enq_data(enq_data), .enq_rdy(enq_rdy),
    .req_vec(req_vec), .grant_vec(grant_vec), .advance(advance),
    .deq_vld(deq_vld), .deq_tid(deq_tid), .deq_data(deq_data),
    .err_ovf(err_ovf), .err_gnt(err_gnt)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mq [4][$];
  logic          m_ovf = 1'b0;
  logic          m_gnt = 1'b0;
  int            n_total = 0;
  int            n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [3:0] m_req();
    logic [3:0] r;
    for (int t = 0; t < 4; t++) r[t] = (mq[t].size() != 0);
    return r;
  endfunction

  task automatic m_clear();
    for (int t = 0; t < 4; t++) mq[t].delete();
    m_ovf = 1'b0;
    m_gnt = 1'b0;
  endtask

  // Compare every output at the falling edge, then advance the model at the rising edge.
  task automatic cycle();
    logic [3:0]    req, rdy, eg;
    int            cnt;
    logic          dv;
    logic [1:0]    tid;
    logic [DW-1:0] dat;
    logic          acc;
    @(negedge clk);
    req = m_req();
    for (int t = 0; t < 4; t++) rdy[t] = (mq[t].size() < DEPTH);
    eg  = grant_vec & req;
    cnt = $countones(eg);
    dv  = (cnt == 1);
    tid = 2'd0;
    for (int t = 0; t < 4; t++) if (dv && eg[t]) tid = 2'(t);
    dat = dv ? mq[tid][0] : '0;
    chk("outputs", 32'({req_vec, enq_rdy, deq_vld, deq_tid, deq_data, err_ovf, err_gnt}),
                   32'({req, rdy, dv, tid, dat, m_ovf, m_gnt}));
    acc = enq_vld && (mq[enq_tid].size() < DEPTH);
    if (enq_vld && !acc) m_ovf = 1'b1;
    if (cnt > 1 || (advance && !dv && ((grant_vec & ~req & 4'b1110) != 4'b0))) m_gnt = 1'b1;
    if (advance && dv) void'(mq[tid].pop_front());
    if (acc) mq[enq_tid].push_back(enq_data);
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_req_vec", 32'(req_vec), 32'h0);
    chk("rst_enq_rdy", 32'(enq_rdy), 32'hF);
    chk("rst_deq_vld", 32'(deq_vld), 32'h0);
    chk("rst_deq_data", 32'(deq_data), 32'h0);
    chk("rst_errs", 32'({err_ovf, err_gnt}), 32'h0);
    #1;
    reset = 1'b0;
    m_clear();
  endtask

  task automatic enq(input logic [1:0] tid, input logic [DW-1:0] d);
    enq_vld = 1'b1; enq_tid = tid; enq_data = d;
    cycle();
    enq_vld = 1'b0;
  endtask

  initial begin
    logic [3:0] req;
    logic [1:0] last;
    int         idx;
    int         k;
    logic [1:0] picks[4];
    int         np;

    #2 reset = 1'b1;
    #1;
    chk("init_req_vec", 32'(req_vec), 32'h0);
    chk("init_enq_rdy", 32'(enq_rdy), 32'hF);
    #9 reset = 1'b0;
    m_clear();
    @(posedge clk); #1;

    // 1: single entry, visible next cycle, popped by its grant.
    enq(2'd2, 8'hA5);
    grant_vec = 4'b0100; advance = 1'b1;
    #2;
    chk("t1_req_vec", 32'(req_vec), 32'h4);
    chk("t1_deq", 32'({deq_vld, deq_tid, deq_data}), 32'({1'b1, 2'd2, 8'hA5}));
    cycle();
    grant_vec = 4'b0; advance = 1'b0;
    #2;
    chk("t1_req_after_pop", 32'(req_vec), 32'h0);

    // 2: overflow on thread 1, FIFO order on pops.
    enq(2'd1, 8'h11);
    enq(2'd1, 8'h22);
    #1;
    chk("t2_enq_rdy1", 32'(enq_rdy[1]), 32'h0);
    enq(2'd1, 8'h33);
    chk("t2_err_ovf", 32'(err_ovf), 32'h1);
    grant_vec = 4'b0010; advance = 1'b1;
    #2; chk("t2_pop1", 32'(deq_data), 32'h11);
    cycle();
    #1; chk("t2_pop2", 32'(deq_data), 32'h22);
    cycle();
    grant_vec = 4'b0; advance = 1'b0;

    // 3: simultaneous enqueue and pop on thread 3.
    do_reset();
    enq(2'd3, 8'h55);
    enq_vld = 1'b1; enq_tid = 2'd3; enq_data = 8'h44;
    grant_vec = 4'b1000; advance = 1'b1;
    #1; chk("t3_old_head", 32'(deq_data), 32'h55);
    cycle();
    enq_vld = 1'b0;
    #1;
    chk("t3_new_head", 32'(deq_data), 32'h44);
    chk("t3_no_ovf", 32'(err_ovf), 32'h0);
    cycle();
    grant_vec = 4'b0; advance = 1'b0;

    // 4: one entry per thread drained by a round-robin arbiter.
    for (int t = 0; t < 4; t++) enq(2'(t), 8'(8'h60 + t));
    last = 2'd3;
    for (int i = 0; i < 4; i++) begin
      req = m_req();
      idx = 0;
      for (k = 4; k >= 1; k--) if (req[(int'(last) + k) % 4]) idx = (int'(last) + k) % 4;
      grant_vec = 4'(1 << idx); advance = 1'b1;
      #1;
      chk("t4_rr_tid", 32'(deq_tid), 32'(i));
      chk("t4_rr_data", 32'(deq_data), 32'(8'h60 + i));
      last = 2'(idx);
      cycle();
    end
    grant_vec = 4'b0; advance = 1'b0;
    #1;
    chk("t4_req_empty", 32'(req_vec), 32'h0);
    chk("t4_err_gnt", 32'(err_gnt), 32'h0);

    // 5: idle park grant is legal; a double grant is flagged.
    grant_vec = 4'b0001; advance = 1'b1;
    #1; chk("t5_idle_deq_vld", 32'(deq_vld), 32'h0);
    cycle();
    chk("t5_idle_err_gnt", 32'(err_gnt), 32'h0);
    grant_vec = 4'b0; advance = 1'b0;
    enq(2'd1, 8'h71);
    enq(2'd2, 8'h72);
    grant_vec = 4'b0110; advance = 1'b1;
    #1; chk("t5_multi_deq_vld", 32'(deq_vld), 32'h0);
    cycle();
    grant_vec = 4'b0; advance = 1'b0;
    #1;
    chk("t5_err_gnt", 32'(err_gnt), 32'h1);
    chk("t5_no_pop", 32'(req_vec), 32'h6);

    // 6: reset with entries pending.
    enq(2'd0, 8'h81);
    grant_vec = 4'b0001;
    do_reset();
    grant_vec = 4'b0;

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      if (n % 400 == 399) do_reset();
      enq_vld  = 1'($urandom_range(0, 1));
      enq_tid  = 2'($urandom_range(0, 3));
      enq_data = 8'($urandom);
      req = m_req();
      if ($urandom_range(0, 31) == 0) begin
        grant_vec = 4'($urandom);
      end else begin
        np = 0;
        for (int t = 0; t < 4; t++) if (req[t]) begin picks[np] = 2'(t); np++; end
        if (np == 0) grant_vec = ($urandom_range(0, 1) == 1) ? 4'b0001 : 4'b0000;
        else grant_vec = 4'(1 << picks[$urandom_range(0, np - 1)]);
      end
      advance = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
